// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types and constants for the crossbar bank schedulers.
package xbar_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Width of a channel index (covers up to 4 channels)
    localparam int CH_ID_W = 2;

    // Wait-counter value at which a channel overrides round-robin
    localparam logic [3:0] AGE_MAX = 4'd15;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority pick. The search starts at ptr
// and wraps modulo N_CH. With no requester, onehot is zero and idx is 0.
module rr_pick
    import xbar_pkg::*;
#(
    parameter int N_CH = 3
) (
    input  logic [N_CH-1:0]    req,
    input  logic [CH_ID_W-1:0] ptr,
    output logic [N_CH-1:0]    onehot,
    output logic [CH_ID_W-1:0] idx
);

    // first requester at or after ptr, wrapping around
    always_comb begin
        logic found;
        int   c;
        found  = 1'b0;
        c      = 0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            c = (int'(ptr) + k) % N_CH;
            if (!found && req[c]) begin
                found     = 1'b1;
                onehot[c] = 1'b1;
                idx       = CH_ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/xbar_bank_sched.sv
// xbar_bank_sched: per-bank scheduler between the channel request buffers
// and one HTU input port. Round-robin pick, valid/ready handshake to the
// HTU, credit flow control and a credit-draining flush.
//
// Optional: define XBAR_SCHED_AGE_EN to add 4-bit per-channel wait
// counters; a channel that has waited AGE_MAX cycles overrides round-robin.
module xbar_bank_sched
    import xbar_pkg::*;
#(
    parameter  int N_CH    = 3,
    parameter  int CREDITS = 4,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_CH-1:0]    ch_req_valid_i,
    output logic [N_CH-1:0]    ch_grant_o,
    output logic               htu_valid_o,
    input  logic               htu_ready_i,
    output logic [CH_ID_W-1:0] htu_ch_id_o,
    input  logic               credit_return_i,
    input  logic               flush_i,
    output logic               flush_done_o,
    output logic [CNT_W-1:0]   credit_cnt_o,
    output logic               credit_ovf_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

    state_t             state;
    logic               flush_pend;
    logic [CH_ID_W-1:0] rr_ptr;
    logic [CH_ID_W-1:0] hold_sel;
    logic [CH_ID_W-1:0] rr_idx;
    logic [CH_ID_W-1:0] run_idx;
    logic [CH_ID_W-1:0] sel;
    logic [N_CH-1:0]    rr_onehot;
    logic [N_CH-1:0]    run_onehot;
    logic [N_CH-1:0]    sel_onehot;
    logic [CNT_W-1:0]   credit_cnt;
    logic               credit_ovf;
    logic               credit_ok;
    logic               valid;
    logic               xfer;

    rr_pick #(.N_CH(N_CH)) u_rr (
        .req    (ch_req_valid_i),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .idx    (rr_idx)
    );

`ifdef XBAR_SCHED_AGE_EN
    logic [3:0]         age [N_CH];
    logic [N_CH-1:0]    aged;
    logic [N_CH-1:0]    age_onehot;
    logic [CH_ID_W-1:0] age_idx;

    // channels that still request after waiting the maximum time
    always_comb begin
        aged = '0;
        for (int c = 0; c < N_CH; c++) begin
            aged[c] = ch_req_valid_i[c] && (age[c] == AGE_MAX);
        end
    end

    // fixed priority among aged channels: lowest index wins
    rr_pick #(.N_CH(N_CH)) u_age (
        .req    (aged),
        .ptr    ('0),
        .onehot (age_onehot),
        .idx    (age_idx)
    );

    // wait counters: count while requesting ungranted, saturate, clear on grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) age[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_grant_o[c]) begin
                    age[c] <= '0;
                end else if (ch_req_valid_i[c] && (age[c] != AGE_MAX)) begin
                    age[c] <= age[c] + 4'd1;
                end
            end
        end
    end

    assign run_idx    = (|aged) ? age_idx    : rr_idx;
    assign run_onehot = (|aged) ? age_onehot : rr_onehot;
`else
    assign run_idx    = rr_idx;
    assign run_onehot = rr_onehot;
`endif

    assign credit_ok = (credit_cnt != '0);

    // selected channel and request valid; HOLD locks onto the stalled channel
    always_comb begin
        sel        = run_idx;
        sel_onehot = run_onehot;
        valid      = 1'b0;
        case (state)
            RUN: begin
                valid = (|ch_req_valid_i) && credit_ok;
            end
            HOLD: begin
                sel        = hold_sel;
                sel_onehot = N_CH'(1) << hold_sel;
                valid      = ch_req_valid_i[hold_sel] && credit_ok;
            end
            default: valid = 1'b0;
        endcase
    end

    assign xfer         = valid && htu_ready_i;
    assign htu_valid_o  = valid;
    assign htu_ch_id_o  = sel;
    assign ch_grant_o   = sel_onehot & {N_CH{xfer}};
    assign flush_done_o = (state == FLUSH) && (credit_cnt == CNT_FULL);
    assign credit_cnt_o = credit_cnt;
    assign credit_ovf_o = credit_ovf;

    // scheduler FSM: stall lock, deferred flush, flush drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RUN;
            hold_sel   <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (valid && !htu_ready_i) begin
                        state      <= HOLD;
                        hold_sel   <= sel;
                        flush_pend <= flush_i;
                    end else if (flush_i) begin
                        state <= FLUSH;
                    end
                end
                HOLD: begin
                    // a dropped request also releases the lock; a pending flush is still honoured
                    if (xfer || !ch_req_valid_i[hold_sel]) begin
                        state      <= (flush_pend || flush_i) ? FLUSH : RUN;
                        flush_pend <= 1'b0;
                    end else if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (credit_cnt == CNT_FULL) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // round-robin pointer moves past the winner on each accepted transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (sel == CH_ID_W'(N_CH - 1)) ? '0 : sel + CH_ID_W'(1);
        end
    end

    // credit counter with saturating return and sticky overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_cnt <= CNT_FULL;
            credit_ovf <= 1'b0;
        end else if (xfer && !credit_return_i) begin
            credit_cnt <= credit_cnt - CNT_W'(1);
        end else if (credit_return_i && !xfer) begin
            if (credit_cnt == CNT_FULL) begin
                credit_ovf <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CNT_W'(1);
            end
        end
    end

    // the locked channel must keep requesting until its transfer is accepted
    hold_req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == HOLD) |-> ch_req_valid_i[hold_sel]);

endmodule
